// File: rtl/tabla_puntuaciones.sv
// Purpose : high-score table kept sorted non-increasing, plus an attract-mode display
//           that blinks between the live score and one table rank per display period.
// Latency : score landing at rank p is written PROFUNDIDAD-p cycles after guardar;
//           display output is registered (1 cycle).
// Backpressure: none queued; guardar is ignored while ocupado is high.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enable              display time-base strobe
//   standBy             1 = table display (attract), 0 = live score shown
//   guardar             one-cycle commit of puntuacionEntrada into the table
//   puntuacionEntrada   live score
//   puntuacionSalida    registered score for the display
//   indiceSalida        registered rank currently displayed
//   ocupado             high for every cycle an insertion is in progress
//   nuevoRecord         one-cycle pulse when a committed score took rank 0
module tabla_puntuaciones #(
  parameter int ANCHO       = 13,
  parameter int PROFUNDIDAD = 4,
  parameter int PERIODO     = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           standBy,
  input  logic                           guardar,
  input  logic [ANCHO-1:0]               puntuacionEntrada,
  output logic [ANCHO-1:0]               puntuacionSalida,
  output logic [$clog2(PROFUNDIDAD)-1:0] indiceSalida,
  output logic                           ocupado,
  output logic                           nuevoRecord
);

  localparam int IW = $clog2(PROFUNDIDAD);
  localparam int CW = $clog2(PERIODO);
  localparam logic [IW-1:0] ULTIMO     = IW'(PROFUNDIDAD - 1);
  localparam logic [CW-1:0] CUENTA_MAX = CW'(PERIODO - 1);
  localparam logic [CW-1:0] MITAD      = CW'(PERIODO / 2);

  typedef enum logic {REPOSO, INSERTA} estado_t;

  estado_t          estado;
  logic [ANCHO-1:0] tabla [PROFUNDIDAD];
  logic [ANCHO-1:0] candidato;
  logic [IW-1:0]    i;
  logic [IW-1:0]    iPrevio;
  logic [CW-1:0]    contador;

  assign iPrevio = i - IW'(1);

  // Insertion walks the candidate upward from the last rank, shifting each
  // smaller entry down by one per cycle (one-pass insertion sort step).
  // Strict '>' keeps a tied candidate below the existing equal entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= REPOSO;
      ocupado     <= 1'b0;
      nuevoRecord <= 1'b0;
      candidato   <= '0;
      i           <= '0;
      for (int k = 0; k < PROFUNDIDAD; k++) begin
        tabla[k] <= '0;
      end
    end else begin
      nuevoRecord <= 1'b0;
      case (estado)
        REPOSO: begin
          // Scores not beating the last rank are dropped without entering INSERTA.
          if (guardar && (puntuacionEntrada > tabla[PROFUNDIDAD-1])) begin
            candidato <= puntuacionEntrada;
            i         <= ULTIMO;
            estado    <= INSERTA;
            ocupado   <= 1'b1;
          end
        end
        INSERTA: begin
          if ((i != '0) && (candidato > tabla[iPrevio])) begin
            tabla[i] <= tabla[iPrevio];
            i        <= iPrevio;
          end else begin
            tabla[i]    <= candidato;
            estado      <= REPOSO;
            ocupado     <= 1'b0;
            nuevoRecord <= (i == '0);
          end
        end
        default: begin
          estado  <= REPOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  // Display: each table rank is held for PERIODO enable ticks; the first half
  // of the period shows the live score, the second half the table entry.
  // The table is read as registered, so an entry mid-shift shows its old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      contador         <= '0;
      indiceSalida     <= '0;
      puntuacionSalida <= '0;
    end else if (!standBy) begin
      contador         <= '0;
      indiceSalida     <= '0;
      puntuacionSalida <= puntuacionEntrada;
    end else begin
      if (enable) begin
        if (contador == CUENTA_MAX) begin
          contador     <= '0;
          indiceSalida <= (indiceSalida == ULTIMO) ? '0 : indiceSalida + IW'(1);
        end else begin
          contador <= contador + CW'(1);
        end
      end
      puntuacionSalida <= (contador >= MITAD) ? tabla[indiceSalida] : puntuacionEntrada;
    end
  end

endmodule

// File: tb/tb_tabla_puntuaciones.sv
// Directed bench for tabla_puntuaciones with ANCHO=13, PROFUNDIDAD=4, PERIODO=4.
// The table is observed only through the attract-mode display output.
module tb_tabla_puntuaciones;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        standBy;
  logic        guardar;
  logic [12:0] puntuacionEntrada;
  logic [12:0] puntuacionSalida;
  logic [1:0]  indiceSalida;
  logic        ocupado;
  logic        nuevoRecord;

  int nChecks = 0;
  int nErrors = 0;

  logic [12:0] leida [4];
  logic [12:0] espSal [16];
  int occ;
  int recs;

  tabla_puntuaciones #(
    .ANCHO(13),
    .PROFUNDIDAD(4),
    .PERIODO(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .standBy(standBy),
    .guardar(guardar),
    .puntuacionEntrada(puntuacionEntrada),
    .puntuacionSalida(puntuacionSalida),
    .indiceSalida(indiceSalida),
    .ocupado(ocupado),
    .nuevoRecord(nuevoRecord)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nChecks++;
    if (obs !== esp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  // Read all four ranks through the display: with PERIODO=4, rank k is on the
  // output after edge 4k+3 counted from a zeroed counter.
  task automatic leerTabla();
    standBy = 1'b0;
    enable  = 1'b0;
    paso();
    standBy = 1'b1;
    enable  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (3) paso();
      leida[k] = puntuacionSalida;
      paso();
    end
    standBy = 1'b0;
    enable  = 1'b0;
    paso();
  endtask

  task automatic compararTabla(input string tag, input int e0, input int e1, input int e2, input int e3);
    leerTabla();
    comprobar({tag, "[0]"}, 32'(leida[0]), 32'(e0));
    comprobar({tag, "[1]"}, 32'(leida[1]), 32'(e1));
    comprobar({tag, "[2]"}, 32'(leida[2]), 32'(e2));
    comprobar({tag, "[3]"}, 32'(leida[3]), 32'(e3));
  endtask

  // Commit v; optionally pulse guardar again with v2 on the first busy cycle.
  // Counts ocupado-high cycles and nuevoRecord pulses over a fixed 8-cycle window.
  task automatic guardarPuntuacion(input logic [12:0] v, input bit repetir, input logic [12:0] v2,
                                   output int nOcupado, output int nRecord);
    puntuacionEntrada = v;
    guardar = 1'b1;
    paso();
    guardar  = 1'b0;
    nOcupado = 0;
    nRecord  = 0;
    for (int c = 0; c < 8; c++) begin
      if (ocupado) nOcupado++;
      if (nuevoRecord) nRecord++;
      if (c == 0 && repetir) begin
        puntuacionEntrada = v2;
        guardar = 1'b1;
      end
      paso();
      if (c == 0 && repetir) begin
        guardar = 1'b0;
        puntuacionEntrada = v;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    standBy = 1'b0;
    guardar = 1'b0;
    puntuacionEntrada = 13'd0;
    paso();
    paso();
    comprobar("reset_salida", 32'(puntuacionSalida), 32'd0);
    comprobar("reset_indice", 32'(indiceSalida), 32'd0);
    comprobar("reset_ocupado", 32'(ocupado), 32'd0);
    comprobar("reset_record", 32'(nuevoRecord), 32'd0);
    reset = 1'b0;
    paso();
    compararTabla("tabla_reset", 0, 0, 0, 0);

    // Zero never beats the empty last rank.
    guardarPuntuacion(13'd0, 1'b0, 13'd0, occ, recs);
    comprobar("cero_ocupado", 32'(occ), 32'd0);

    // 100 into an empty table climbs to rank 0 (4 cycles) and is itself a new record.
    guardarPuntuacion(13'd100, 1'b0, 13'd0, occ, recs);
    comprobar("g100_ocupado", 32'(occ), 32'd4);
    comprobar("g100_record", 32'(recs), 32'd1);
    guardarPuntuacion(13'd300, 1'b0, 13'd0, occ, recs);
    comprobar("g300_ocupado", 32'(occ), 32'd4);
    comprobar("g300_record", 32'(recs), 32'd1);
    guardarPuntuacion(13'd200, 1'b0, 13'd0, occ, recs);
    comprobar("g200_ocupado", 32'(occ), 32'd3);
    comprobar("g200_record", 32'(recs), 32'd0);
    compararTabla("tabla_300_200_100", 300, 200, 100, 0);

    guardarPuntuacion(13'd400, 1'b0, 13'd0, occ, recs);
    comprobar("g400_record", 32'(recs), 32'd1);
    compararTabla("tabla_llena", 400, 300, 200, 100);
    guardarPuntuacion(13'd50, 1'b0, 13'd0, occ, recs);
    comprobar("g50_ocupado", 32'(occ), 32'd0);
    comprobar("g50_record", 32'(recs), 32'd0);
    compararTabla("tabla_sin_50", 400, 300, 200, 100);
    guardarPuntuacion(13'd250, 1'b0, 13'd0, occ, recs);
    comprobar("g250_ocupado", 32'(occ), 32'd2);
    compararTabla("tabla_250", 400, 300, 250, 200);

    // Rebuild {400,300,200,100} from reset.
    reset = 1'b1;
    paso();
    reset = 1'b0;
    guardarPuntuacion(13'd400, 1'b0, 13'd0, occ, recs);
    guardarPuntuacion(13'd300, 1'b0, 13'd0, occ, recs);
    guardarPuntuacion(13'd200, 1'b0, 13'd0, occ, recs);
    guardarPuntuacion(13'd100, 1'b0, 13'd0, occ, recs);
    comprobar("g100_ultimo_ocupado", 32'(occ), 32'd1);

    // Attract display: live 7 blinks with each rank in turn.
    espSal = '{13'd7, 13'd7, 13'd400, 13'd400, 13'd7, 13'd7, 13'd300, 13'd300,
               13'd7, 13'd7, 13'd200, 13'd200, 13'd7, 13'd7, 13'd100, 13'd100};
    puntuacionEntrada = 13'd7;
    standBy = 1'b0;
    paso();
    standBy = 1'b1;
    enable  = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      paso();
      comprobar($sformatf("display_salida_%0d", n), 32'(puntuacionSalida), 32'(espSal[n-1]));
      comprobar($sformatf("display_indice_%0d", n), 32'(indiceSalida), 32'((n / 4) % 4));
    end
    // Drop standBy part-way through rank 1.
    repeat (6) paso();
    comprobar("display_indice_previo", 32'(indiceSalida), 32'd1);
    standBy = 1'b0;
    puntuacionEntrada = 13'd55;
    paso();
    comprobar("standby_bajo_salida", 32'(puntuacionSalida), 32'd55);
    comprobar("standby_bajo_indice", 32'(indiceSalida), 32'd0);
    enable = 1'b0;

    // Tie goes below the existing 300; a second guardar while busy is ignored.
    guardarPuntuacion(13'd300, 1'b1, 13'd350, occ, recs);
    comprobar("empate_ocupado", 32'(occ), 32'd2);
    comprobar("empate_record", 32'(recs), 32'd0);
    compararTabla("tabla_empate", 400, 300, 300, 200);

    // Reset in the middle of an insertion aborts it.
    puntuacionEntrada = 13'd500;
    guardar = 1'b1;
    paso();
    guardar = 1'b0;
    paso();
    comprobar("medio_insercion_ocupado", 32'(ocupado), 32'd1);
    reset = 1'b1;
    paso();
    comprobar("abort_ocupado", 32'(ocupado), 32'd0);
    comprobar("abort_record", 32'(nuevoRecord), 32'd0);
    reset = 1'b0;
    recs = 0;
    occ  = 0;
    for (int c = 0; c < 6; c++) begin
      if (nuevoRecord) recs++;
      if (ocupado) occ++;
      paso();
    end
    comprobar("abort_sin_record", 32'(recs), 32'd0);
    comprobar("abort_sin_ocupado", 32'(occ), 32'd0);
    compararTabla("tabla_abort", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
